pipe_ctrl: RTL and testbench

- Pipeline sequencing controller for the five-block integer core (pc_reg, ifetch/if_id, id/id_ex, ex).
- Resolves taken jumps, multicycle-EX stalls, load-use hazards and external halt/resume into hold/flush/load controls for the PC and the two pipeline registers.
- Carries a small FSM for multi-cycle flush and halt, plus stall-watchdog and bubble counters.

---
 rtl/pipe_ctrl_pkg.sv | 21 ++
 rtl/pipe_ctrl_if.sv | 58 +++++
 rtl/pipe_ctrl_hazard_det.sv | 25 ++
 rtl/pipe_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller.
//   - ctrl_state_e : controller FSM encoding (RUN / FLUSH / HALT)
//   - NOP_INSN     : instruction loaded into IF/ID on a flush (addi x0,x0,0)
//   - REG_ADDR_W   : architectural register-address width
//   - sat_inc32    : saturating 32-bit increment used by the bubble counter
package pipe_ctrl_pkg;

  localparam int          REG_ADDR_W = 5;
  localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } ctrl_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline datapath and the sequencing controller.
// Handshake semantics: there is no valid/ready pair here. Every input is a
// per-cycle level sampled on the rising clk edge (resume_i is expected as a
// one-cycle pulse); every output is a same-cycle combinational control that
// the pipeline registers obey on the next rising edge.
//   master : pipeline side (drives status, consumes controls)
//   slave  : controller side (consumes status, drives controls)
//   state_dbg exposes the controller FSM state for checkers.
interface pipe_ctrl_if #(
  parameter int ADDR_W = 32
);
  import pipe_ctrl_pkg::*;

  // status from the pipeline
  logic                  jump_en_i;
  logic [ADDR_W-1:0]     jump_addr_i;
  logic                  ex_busy_i;
  logic [REG_ADDR_W-1:0] id_rs1_addr_i;
  logic [REG_ADDR_W-1:0] id_rs2_addr_i;
  logic                  id_rs1_used_i;
  logic                  id_rs2_used_i;
  logic [REG_ADDR_W-1:0] id_ex_rd_addr_i;
  logic                  id_ex_mem_rd_i;
  logic                  halt_req_i;
  logic                  resume_i;

  // controls to the pipeline
  logic                  pc_hold_o;
  logic                  pc_load_o;
  logic [ADDR_W-1:0]     pc_load_addr_o;
  logic                  if_id_hold_o;
  logic                  if_id_flush_o;
  logic                  id_ex_hold_o;
  logic                  id_ex_flush_o;
  logic                  halted_o;
  logic                  stall_timeout_o;
  logic [31:0]           bubble_cnt_o;
  ctrl_state_e           state_dbg;

  modport master (
    output jump_en_i, jump_addr_i, ex_busy_i, id_rs1_addr_i, id_rs2_addr_i,
           id_rs1_used_i, id_rs2_used_i, id_ex_rd_addr_i, id_ex_mem_rd_i,
           halt_req_i, resume_i,
    input  pc_hold_o, pc_load_o, pc_load_addr_o, if_id_hold_o, if_id_flush_o,
           id_ex_hold_o, id_ex_flush_o, halted_o, stall_timeout_o,
           bubble_cnt_o, state_dbg
  );

  modport slave (
    input  jump_en_i, jump_addr_i, ex_busy_i, id_rs1_addr_i, id_rs2_addr_i,
           id_rs1_used_i, id_rs2_used_i, id_ex_rd_addr_i, id_ex_mem_rd_i,
           halt_req_i, resume_i,
    output pc_hold_o, pc_load_o, pc_load_addr_o, if_id_hold_o, if_id_flush_o,
           id_ex_hold_o, id_ex_flush_o, halted_o, stall_timeout_o,
           bubble_cnt_o, state_dbg
  );

endinterface

// File: rtl/pipe_ctrl_hazard_det.sv
// Load-use hazard detector (purely combinational).
// Ports:
//   rs1_addr, rs2_addr : source registers of the instruction in ID
//   rs1_used, rs2_used : ID instruction actually reads that source
//   rd_addr            : destination of the instruction in EX
//   mem_rd             : instruction in EX is a load
//   load_use           : ID needs a value the load in EX has not produced yet
module pipe_hazard_det
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  mem_rd,
  output logic                  load_use
);

  // x0 is never written, so a load targeting it cannot create a hazard.
  assign load_use = mem_rd & (rd_addr != '0) &
                    ((rs1_used & (rs1_addr == rd_addr)) |
                     (rs2_used & (rs2_addr == rd_addr)));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: turns taken jumps, multicycle-EX stalls,
// load-use hazards and debug halt/resume into hold/flush/load controls for
// the PC, IF/ID and ID/EX registers.
// Ports:
//   clk, rst : core clock, synchronous active-high reset
//   bus      : pipe_ctrl_if.slave (status in, controls out, state_dbg)
// Parameters:
//   FLUSH_CYCLES  : cycles IF/ID stays flushed after a taken jump (1..8)
//   STALL_TIMEOUT : consecutive ex_busy_i cycles that trip the watchdog
//   ADDR_W        : PC / jump target width
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES  = 1,
  parameter int STALL_TIMEOUT = 64,
  parameter int ADDR_W        = 32
) (
  input  logic      clk,
  input  logic      rst,
  pipe_ctrl_if.slave bus
);

  localparam int FCNT_W = 3;
  localparam int WCNT_W = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;
  localparam logic [FCNT_W-1:0] FCNT_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX    = WCNT_W'(STALL_TIMEOUT - 1);

  ctrl_state_e       state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [WCNT_W-1:0] wcnt_q;
  logic              flag_q;
  logic [31:0]       bubble_q;

  logic              load_use;
  logic              wd_hit;

  logic              pc_hold, pc_load, if_id_hold, if_id_flush;
  logic              id_ex_hold, id_ex_flush;
  logic [ADDR_W-1:0] pc_load_addr;

  pipe_hazard_det u_hazard (
    .rs1_addr (bus.id_rs1_addr_i),
    .rs2_addr (bus.id_rs2_addr_i),
    .rs1_used (bus.id_rs1_used_i),
    .rs2_used (bus.id_rs2_used_i),
    .rd_addr  (bus.id_ex_rd_addr_i),
    .mem_rd   (bus.id_ex_mem_rd_i),
    .load_use (load_use)
  );

  // Next-state and controls. Everything is forced to 0 while rst is high so
  // an abandoned flush or halt cannot leak controls into the reset cycle.
  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    pc_hold      = 1'b0;
    pc_load      = 1'b0;
    pc_load_addr = '0;
    if_id_hold   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_hold   = 1'b0;
    id_ex_flush  = 1'b0;

    if (!rst) begin
      case (state_q)
        ST_RUN: begin
          if (bus.jump_en_i) begin
            // EX owns the jump, so a concurrent ex_busy_i is irrelevant.
            pc_load      = 1'b1;
            pc_load_addr = bus.jump_addr_i;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = ST_FLUSH;
              fcnt_d  = FCNT_RELOAD;
            end
          end else if (bus.ex_busy_i) begin
            pc_hold    = 1'b1;
            if_id_hold = 1'b1;
            id_ex_hold = 1'b1;
          end else if (load_use) begin
            // One bubble is enough: next cycle the load has left EX.
            pc_hold     = 1'b1;
            if_id_hold  = 1'b1;
            id_ex_flush = 1'b1;
          end else if (bus.halt_req_i) begin
            state_d     = ST_HALT;
            pc_hold     = 1'b1;
            if_id_hold  = 1'b1;
            id_ex_flush = 1'b1;
          end
        end

        ST_FLUSH: begin
          // Only bubbles are in flight, so busy and load-use do not matter.
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (bus.jump_en_i) begin
            pc_load      = 1'b1;
            pc_load_addr = bus.jump_addr_i;
            fcnt_d       = FCNT_RELOAD;
          end else begin
            fcnt_d = fcnt_q - 1'b1;
            if (fcnt_q == FCNT_W'(1)) state_d = ST_RUN;
          end
        end

        ST_HALT: begin
          // Keep the front end frozen while the instruction in EX drains.
          pc_hold     = 1'b1;
          if_id_hold  = 1'b1;
          id_ex_flush = 1'b1;
          if (bus.jump_en_i) begin
            // The redirect wins over the freeze; IF/ID flush beats its hold.
            pc_hold      = 1'b0;
            pc_load      = 1'b1;
            pc_load_addr = bus.jump_addr_i;
            if_id_hold   = 1'b0;
            if_id_flush  = 1'b1;
          end
          if (bus.resume_i && !bus.halt_req_i) state_d = ST_RUN;
        end

        default: state_d = ST_RUN;
      endcase
    end
  end

  // Watchdog trips in the STALL_TIMEOUT-th consecutive busy cycle itself.
  assign wd_hit = bus.ex_busy_i & (wcnt_q == WCNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      fcnt_q   <= '0;
      wcnt_q   <= '0;
      flag_q   <= 1'b0;
      bubble_q <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      if (!bus.ex_busy_i)       wcnt_q <= '0;
      else if (wcnt_q != WCNT_MAX) wcnt_q <= wcnt_q + 1'b1;
      if (wd_hit)      flag_q   <= 1'b1;
      if (id_ex_flush) bubble_q <= sat_inc32(bubble_q);
    end
  end

  assign bus.pc_hold_o       = pc_hold;
  assign bus.pc_load_o       = pc_load;
  assign bus.pc_load_addr_o  = pc_load_addr;
  assign bus.if_id_hold_o    = if_id_hold;
  assign bus.if_id_flush_o   = if_id_flush;
  assign bus.id_ex_hold_o    = id_ex_hold;
  assign bus.id_ex_flush_o   = id_ex_flush;
  assign bus.halted_o        = ~rst & (state_q == ST_HALT);
  assign bus.stall_timeout_o = ~rst & (flag_q | wd_hit);
  assign bus.bubble_cnt_o    = rst ? 32'd0 : bubble_q;
  assign bus.state_dbg       = rst ? ST_RUN : state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl (FLUSH_CYCLES=3, STALL_TIMEOUT=4).
// Inputs are applied 1 time unit after the rising edge; outputs are sampled
// on the falling edge and compared with a behavioural model.
module tb_pipe_ctrl;
  localparam int FC     = 3;
  localparam int ST     = 4;
  localparam int ADDR_W = 32;

  typedef struct packed {
    logic [1:0]  state;
    logic        pc_hold;
    logic        pc_load;
    logic [31:0] addr;
    logic        if_id_hold;
    logic        if_id_flush;
    logic        id_ex_hold;
    logic        id_ex_flush;
    logic        halted;
    logic        stall;
    logic [31:0] bubble;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  typedef struct {
    bit          rst;
    bit          jump;
    logic [31:0] ja;
    bit          busy;
    logic [4:0]  rs1, rs2, rd;
    bit          u1, u2, mem_rd;
    bit          halt;
    bit          resume;
  } stim_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  pipe_ctrl #(.FLUSH_CYCLES(FC), .STALL_TIMEOUT(ST), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Abstract view: number of flush cycles still owed after a jump, a halted
  // flag, the length of the current busy run and a bubble total.
  int          m_flush_left = 0;
  bit          m_halted     = 0;
  int          m_busy_run   = 0;
  bit          m_flag       = 0;
  logic [31:0] m_bubbles    = 0;

  function automatic exp_t model_step(input stim_t s);
    exp_t e;
    bit   lu;
    bit   flag_now;
    e  = '0;
    lu = s.mem_rd && (s.rd != 0) && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    if (s.rst) begin
      m_flush_left = 0; m_halted = 0; m_busy_run = 0; m_flag = 0; m_bubbles = 0;
      return e;
    end
    e.state  = m_halted ? 2'd2 : (m_flush_left > 0 ? 2'd1 : 2'd0);
    e.halted = m_halted;
    e.bubble = m_bubbles;
    if (m_halted) begin
      e.pc_hold = 1; e.if_id_hold = 1; e.id_ex_flush = 1;
      if (s.jump) begin
        e.pc_hold = 0; e.pc_load = 1; e.addr = s.ja;
        e.if_id_hold = 0; e.if_id_flush = 1;
      end
      if (s.resume && !s.halt) m_halted = 0;
    end else if (m_flush_left > 0) begin
      e.if_id_flush = 1; e.id_ex_flush = 1;
      if (s.jump) begin
        e.pc_load = 1; e.addr = s.ja; m_flush_left = FC - 1;
      end else begin
        m_flush_left--;
      end
    end else if (s.jump) begin
      e.pc_load = 1; e.addr = s.ja; e.if_id_flush = 1; e.id_ex_flush = 1;
      m_flush_left = FC - 1;
    end else if (s.busy) begin
      e.pc_hold = 1; e.if_id_hold = 1; e.id_ex_hold = 1;
    end else if (lu) begin
      e.pc_hold = 1; e.if_id_hold = 1; e.id_ex_flush = 1;
    end else if (s.halt) begin
      e.pc_hold = 1; e.if_id_hold = 1; e.id_ex_flush = 1;
      m_halted = 1;
    end
    // This busy cycle is number m_busy_run+1 of the run.
    flag_now   = m_flag || (s.busy && (m_busy_run + 1 >= ST));
    e.stall    = flag_now;
    m_flag     = flag_now;
    m_busy_run = s.busy ? m_busy_run + 1 : 0;
    if (e.id_ex_flush && m_bubbles != 32'hFFFF_FFFF) m_bubbles = m_bubbles + 1;
    return e;
  endfunction

  // ---------------- driver ----------------
  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.jump = 0; s.ja = '0; s.busy = 0;
    s.rs1 = '0; s.rs2 = '0; s.rd = '0; s.u1 = 0; s.u2 = 0; s.mem_rd = 0;
    s.halt = 0; s.resume = 0;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    rst                  = s.rst;
    bus.jump_en_i        = s.jump;
    bus.jump_addr_i      = s.ja;
    bus.ex_busy_i        = s.busy;
    bus.id_rs1_addr_i    = s.rs1;
    bus.id_rs2_addr_i    = s.rs2;
    bus.id_ex_rd_addr_i  = s.rd;
    bus.id_rs1_used_i    = s.u1;
    bus.id_rs2_used_i    = s.u2;
    bus.id_ex_mem_rd_i   = s.mem_rd;
    bus.halt_req_i       = s.halt;
    bus.resume_i         = s.resume;
  endtask

  // One clock cycle: drive, predict, sample on the falling edge, compare.
  task automatic tick(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    apply(s);
    exp_q.push_back(EXP_W'(model_step(s)));
    @(negedge clk);
    e = exp_t'(exp_q.pop_front());
    check("state",         64'(bus.state_dbg),       64'(e.state));
    check("pc_hold",       64'(bus.pc_hold_o),       64'(e.pc_hold));
    check("pc_load",       64'(bus.pc_load_o),       64'(e.pc_load));
    check("pc_load_addr",  64'(bus.pc_load_addr_o),  64'(e.addr));
    check("if_id_hold",    64'(bus.if_id_hold_o),    64'(e.if_id_hold));
    check("if_id_flush",   64'(bus.if_id_flush_o),   64'(e.if_id_flush));
    check("id_ex_hold",    64'(bus.id_ex_hold_o),    64'(e.id_ex_hold));
    check("id_ex_flush",   64'(bus.id_ex_flush_o),   64'(e.id_ex_flush));
    check("halted",        64'(bus.halted_o),        64'(e.halted));
    check("stall_timeout", 64'(bus.stall_timeout_o), 64'(e.stall));
    check("bubble_cnt",    64'(bus.bubble_cnt_o),    64'(e.bubble));
  endtask

  task automatic do_reset();
    stim_t s;
    s = idle(); s.rst = 1;
    tick(s);
    tick(s);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    stim_t s;
    bit    halt_lvl;
    bit    busy_lvl;
    s = idle(); s.rst = 1;
    apply(s);

    // Reset state
    do_reset();
    check("rst_bubble", 64'(bus.bubble_cnt_o), 64'd0);
    check("rst_pc_hold", 64'(bus.pc_hold_o), 64'd0);

    // Load-use: one bubble, then rd=0 gives no stall
    s = idle(); s.mem_rd = 1; s.rd = 5'd5; s.rs2 = 5'd5; s.u2 = 1;
    tick(s);
    check("lu_pc_hold", 64'(bus.pc_hold_o), 64'd1);
    check("lu_flush", 64'(bus.id_ex_flush_o), 64'd1);
    tick(idle());
    check("lu_one_cycle", 64'(bus.pc_hold_o), 64'd0);
    check("lu_bubble", 64'(bus.bubble_cnt_o), 64'd1);
    s.rd = 5'd0; s.rs2 = 5'd0;
    tick(s);
    check("lu_rd0_no_stall", 64'(bus.pc_hold_o), 64'd0);

    // Jump with three flush cycles
    do_reset();
    s = idle(); s.jump = 1; s.ja = 32'h100;
    tick(s);
    check("jmp_addr", 64'(bus.pc_load_addr_o), 64'h100);
    check("jmp_load", 64'(bus.pc_load_o), 64'd1);
    tick(idle());
    check("jmp_flush2", 64'(bus.if_id_flush_o), 64'd1);
    tick(idle());
    check("jmp_flush3", 64'(bus.if_id_flush_o), 64'd1);
    tick(idle());
    check("jmp_back_run", 64'(bus.if_id_flush_o), 64'd0);
    check("jmp_bubbles", 64'(bus.bubble_cnt_o), 64'd3);

    // Priority: jump + busy + load-use, then a re-jump during FLUSH
    do_reset();
    s = idle(); s.jump = 1; s.ja = 32'h200; s.busy = 1;
    s.mem_rd = 1; s.rd = 5'd7; s.rs1 = 5'd7; s.u1 = 1;
    tick(s);
    check("prio_no_pc_hold", 64'(bus.pc_hold_o), 64'd0);
    check("prio_no_ex_hold", 64'(bus.id_ex_hold_o), 64'd0);
    tick(idle());
    s = idle(); s.jump = 1; s.ja = 32'h300;
    tick(s);
    check("rejump_load", 64'(bus.pc_load_o), 64'd1);
    tick(idle());
    tick(idle());
    check("rejump_flush", 64'(bus.id_ex_flush_o), 64'd1);
    tick(idle());
    check("rejump_done", 64'(bus.id_ex_flush_o), 64'd0);

    // Watchdog: 3 busy cycles no trip, 4 busy cycles trip, sticky until rst
    do_reset();
    s = idle(); s.busy = 1;
    repeat (3) tick(s);
    check("wd_3_clear", 64'(bus.stall_timeout_o), 64'd0);
    tick(idle());
    repeat (3) tick(s);
    check("wd_pre", 64'(bus.stall_timeout_o), 64'd0);
    tick(s);
    check("wd_4th", 64'(bus.stall_timeout_o), 64'd1);
    repeat (3) tick(idle());
    check("wd_sticky", 64'(bus.stall_timeout_o), 64'd1);
    do_reset();
    check("wd_rst", 64'(bus.stall_timeout_o), 64'd0);

    // Halt / resume
    s = idle(); s.halt = 1;
    tick(s);
    tick(s);
    check("halt_on", 64'(bus.halted_o), 64'd1);
    s.resume = 1;
    tick(s);
    s.resume = 0;
    tick(s);
    check("halt_resume_ignored", 64'(bus.halted_o), 64'd1);
    s = idle(); s.resume = 1;
    tick(s);
    tick(idle());
    check("halt_off", 64'(bus.halted_o), 64'd0);
    check("halt_ctrl_zero", 64'(bus.pc_hold_o), 64'd0);

    // Reset during FLUSH and during HALT
    s = idle(); s.jump = 1; s.ja = 32'h40;
    tick(s);
    do_reset();
    tick(idle());
    check("rst_flush_gone", 64'(bus.if_id_flush_o), 64'd0);
    s = idle(); s.halt = 1;
    tick(s);
    tick(s);
    do_reset();
    tick(idle());
    check("rst_halt_gone", 64'(bus.halted_o), 64'd0);

    // Randomized traffic
    halt_lvl = 0;
    busy_lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      s = idle();
      if ($urandom_range(0, 19) == 0) halt_lvl = ~halt_lvl;
      if ($urandom_range(0, 3) == 0)  busy_lvl = ~busy_lvl;
      s.rst    = ($urandom_range(0, 149) == 0);
      s.jump   = ($urandom_range(0, 7) == 0);
      s.ja     = $urandom;
      s.busy   = busy_lvl;
      s.mem_rd = $urandom_range(0, 1) == 1;
      s.rd     = 5'($urandom_range(0, 3));
      s.rs1    = 5'($urandom_range(0, 3));
      s.rs2    = 5'($urandom_range(0, 3));
      s.u1     = $urandom_range(0, 1) == 1;
      s.u2     = $urandom_range(0, 1) == 1;
      s.halt   = halt_lvl;
      s.resume = ($urandom_range(0, 4) == 0);
      tick(s);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
